// File: rtl/a_plus_b_using_fifos_and_double_buffer_pkg.sv
// Shared constants and helpers for the streaming a+b adder.
package a_plus_b_using_fifos_and_double_buffer_pkg;

    localparam logic [1:0] db_entries = 2'd2;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/a_plus_b_using_fifos_and_double_buffer_flip_flop_fifo.sv
// Register-array FIFO with combinational head read and wrap-bit pointers.
module flip_flop_fifo
    import a_plus_b_using_fifos_and_double_buffer_pkg::*;
#(
    parameter int width = 4,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] write_data,
    output logic [width-1:0] read_data,
    output logic             empty,
    output logic             full
);

    localparam int aw = addr_width(depth);
    localparam logic [aw:0] ptr_one = {{aw{1'b0}}, 1'b1};

    logic [width-1:0] r_mem [depth];
    logic [aw:0]      r_wr_ptr;
    logic [aw:0]      r_rd_ptr;

    // Pointer update; callers never push when full nor pop when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {(aw+1){1'b0}};
            r_rd_ptr <= {(aw+1){1'b0}};
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + ptr_one;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + ptr_one;
            end
        end
    end

    // Storage write; contents are meaningless while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr[aw-1:0]] <= write_data;
        end
    end

    assign read_data = r_mem[r_rd_ptr[aw-1:0]];
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[aw] != r_rd_ptr[aw]) &&
                       (r_wr_ptr[aw-1:0] == r_rd_ptr[aw-1:0]);

endmodule

// File: rtl/a_plus_b_using_fifos_and_double_buffer.sv
// Pairs two independent operand streams through FIFOs and emits their
// wrap-around sum through a registered 2-entry double buffer.
module a_plus_b_using_fifos_and_double_buffer
    import a_plus_b_using_fifos_and_double_buffer_pkg::*;
#(
    parameter int width = 4,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [width-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [width-1:0] b_data,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [width-1:0] sum_data
);

    logic [width-1:0] w_a_head;
    logic [width-1:0] w_b_head;
    logic [width-1:0] w_sum;
    logic             w_a_empty;
    logic             w_a_full;
    logic             w_b_empty;
    logic             w_b_full;
    logic             w_a_push;
    logic             w_b_push;
    logic             w_pop;
    logic             w_db_full;
    logic             w_db_read;

    logic [width-1:0] r_db_data [2];
    logic             r_db_wr_ptr;
    logic             r_db_rd_ptr;
    logic [1:0]       r_db_count;

    assign w_a_push = a_valid & ~w_a_full;
    assign w_b_push = b_valid & ~w_b_full;
    assign a_ready  = ~w_a_full;
    assign b_ready  = ~w_b_full;

    flip_flop_fifo #(.width(width), .depth(depth)) u_fifo_a (
        .clk        (clk),
        .rst        (rst),
        .push       (w_a_push),
        .pop        (w_pop),
        .write_data (a_data),
        .read_data  (w_a_head),
        .empty      (w_a_empty),
        .full       (w_a_full)
    );

    flip_flop_fifo #(.width(width), .depth(depth)) u_fifo_b (
        .clk        (clk),
        .rst        (rst),
        .push       (w_b_push),
        .pop        (w_pop),
        .write_data (b_data),
        .read_data  (w_b_head),
        .empty      (w_b_empty),
        .full       (w_b_full)
    );

    // Space is judged from the registered count only, so sum_ready never
    // reaches the pop path combinationally.
    assign w_db_full = (r_db_count == db_entries);
    assign w_pop     = ~w_a_empty & ~w_b_empty & ~w_db_full;
    assign w_sum     = w_a_head + w_b_head;
    assign sum_valid = (r_db_count != 2'd0);
    assign sum_data  = r_db_data[r_db_rd_ptr];
    assign w_db_read = sum_valid & sum_ready;

    // Double-buffer pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_wr_ptr <= 1'b0;
            r_db_rd_ptr <= 1'b0;
            r_db_count  <= 2'd0;
        end else begin
            if (w_pop) begin
                r_db_wr_ptr <= ~r_db_wr_ptr;
            end
            if (w_db_read) begin
                r_db_rd_ptr <= ~r_db_rd_ptr;
            end
            case ({w_pop, w_db_read})
                2'b10:   r_db_count <= r_db_count + 2'd1;
                2'b01:   r_db_count <= r_db_count - 2'd1;
                default: r_db_count <= r_db_count;
            endcase
        end
    end

    // Double-buffer data capture.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_db_data[r_db_wr_ptr] <= w_sum;
        end
    end

endmodule

// File: tb/tb_a_plus_b_using_fifos_and_double_buffer.sv
// Scoreboard bench: accepted operands feed a model queue; a monitor checks each sum.
module tb_a_plus_b_using_fifos_and_double_buffer;

    localparam int width = 4;
    localparam int depth = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             a_valid, b_valid, sum_ready;
    logic             a_ready, b_ready, sum_valid;
    logic [width-1:0] a_data, b_data, sum_data;

    int tests_run    = 0;
    int tests_failed = 0;
    int n_a = 0, n_b = 0, n_sum = 0;
    logic [width-1:0] a_q[$], b_q[$], exp_q[$];
    logic [width-1:0] mon_sum;

    a_plus_b_using_fifos_and_double_buffer #(.width(width), .depth(depth)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_data    (b_data),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .sum_data  (sum_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: record accepted operands, build expected sums, check outputs.
    always @(negedge clk) begin
        if (rst) begin
            a_q.delete();
            b_q.delete();
            exp_q.delete();
        end else begin
            if (a_valid && a_ready) begin
                a_q.push_back(a_data);
                n_a++;
            end
            if (b_valid && b_ready) begin
                b_q.push_back(b_data);
                n_b++;
            end
            while (a_q.size() > 0 && b_q.size() > 0) begin
                mon_sum = a_q.pop_front() + b_q.pop_front();
                exp_q.push_back(mon_sum);
            end
            if (sum_valid && sum_ready) begin
                n_sum++;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_sum: got %0d expected none", sum_data);
                end else begin
                    check("sum_order", int'(sum_data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    int base_a, base_b, base_s, cnt, cnt2;
    logic [width-1:0] held;

    initial begin
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; sum_ready = 1'b0;
        a_data = '0; b_data = '0;
        tick(); tick();
        sample();
        check("reset_sum_valid", sum_valid, 0);
        check("reset_a_ready", a_ready, 1);
        check("reset_b_ready", b_ready, 1);
        tick(); rst = 1'b0;

        // 3 + 5 with latency check
        a_valid = 1'b1; b_valid = 1'b1; a_data = 4'd3; b_data = 4'd5; sum_ready = 1'b1;
        tick(); a_valid = 1'b0; b_valid = 1'b0;
        sample(); check("lat_n1_valid", sum_valid, 0);
        sample(); check("lat_n2_valid", sum_valid, 1);
        check("sum_3_5", sum_data, 8);
        sample(); check("after_sum_valid", sum_valid, 0);

        // 9 + 9 wraps to 2
        tick(); a_valid = 1'b1; b_valid = 1'b1; a_data = 4'd9; b_data = 4'd9;
        tick(); a_valid = 1'b0; b_valid = 1'b0;
        sample(); sample();
        check("wrap_valid", sum_valid, 1);
        check("sum_9_9", sum_data, 2);

        // back-to-back random, one sum per cycle
        tick(); base_s = n_sum; cnt = 0; cnt2 = 0;
        for (int i = 0; i < 20; i++) begin
            a_valid = 1'b1; b_valid = 1'b1;
            a_data = width'($urandom); b_data = width'($urandom);
            sample();
            if (!(a_ready && b_ready)) cnt++;
            if (i >= 2 && sum_valid) cnt2++;
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (4) sample();
        check("b2b_not_ready_cycles", cnt, 0);
        check("b2b_valid_cycles", cnt2, 18);
        check("b2b_sum_count", n_sum - base_s, 20);

        // only a supplied
        tick(); base_a = n_a; base_b = n_b; base_s = n_sum;
        for (int i = 0; i < 20; i++) begin
            a_valid = 1'b1; a_data = width'(i);
            tick();
        end
        sample();
        check("a_only_count", n_a - base_a, 4);
        check("a_only_a_ready", a_ready, 0);
        check("a_only_b_ready", b_ready, 1);
        tick(); a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_valid = 1'b1; b_data = width'(10 + i);
            tick();
        end
        b_valid = 1'b0;
        repeat (5) sample();
        check("a_only_b_count", n_b - base_b, 4);
        check("a_only_sums", n_sum - base_s, 4);
        check("a_only_a_ready_back", a_ready, 1);

        // consumer stalled: depth + 2 pairs accepted
        tick(); sum_ready = 1'b0; base_a = n_a; base_b = n_b; base_s = n_sum;
        for (int i = 0; i < 20; i++) begin
            a_valid = 1'b1; b_valid = 1'b1;
            a_data = width'(i + 1); b_data = width'(2 * i);
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        sample();
        check("stall_a_count", n_a - base_a, 6);
        check("stall_b_count", n_b - base_b, 6);
        check("stall_a_ready", a_ready, 0);
        check("stall_b_ready", b_ready, 0);
        check("stall_sum_valid", sum_valid, 1);
        held = sum_data;
        check("stall_head_value", sum_data, 1);
        repeat (3) sample();
        check("stall_held_data", sum_data, held);
        check("stall_held_valid", sum_valid, 1);
        tick(); sum_ready = 1'b1;
        repeat (10) sample();
        check("stall_drain_sums", n_sum - base_s, 6);
        tick(); a_valid = 1'b1; b_valid = 1'b1; a_data = 4'd1; b_data = 4'd1;
        tick(); a_valid = 1'b0; b_valid = 1'b0;
        repeat (4) sample();
        check("stall_resume_sums", n_sum - base_s, 7);

        // random valids and consumer until 100 sums
        tick(); base_a = n_a; base_b = n_b; base_s = n_sum;
        for (int c = 0; c < 3000 && (n_sum - base_s) < 100; c++) begin
            a_valid   = 1'($urandom_range(1)) && ((n_a - base_a) < 100);
            b_valid   = 1'($urandom_range(1)) && ((n_b - base_b) < 100);
            a_data    = width'($urandom);
            b_data    = width'($urandom);
            sum_ready = 1'($urandom_range(1));
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0; sum_ready = 1'b1;
        repeat (2 * depth + 3) sample();
        check("rand_a_count", n_a - base_a, 100);
        check("rand_b_count", n_b - base_b, 100);
        check("rand_sum_count", n_sum - base_s, 100);
        check("rand_model_empty", exp_q.size() + a_q.size() + b_q.size(), 0);

        // reset with 3 pairs buffered
        tick(); sum_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; b_valid = 1'b1; a_data = width'(i + 4); b_data = width'(i);
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick(); rst = 1'b0;
        sample();
        check("midrst_sum_valid", sum_valid, 0);
        check("midrst_a_ready", a_ready, 1);
        check("midrst_b_ready", b_ready, 1);
        base_s = n_sum;
        tick(); sum_ready = 1'b1;
        repeat (6) sample();
        check("midrst_no_stale", n_sum - base_s, 0);
        tick(); a_valid = 1'b1; b_valid = 1'b1; a_data = 4'd1; b_data = 4'd2;
        tick(); a_valid = 1'b0; b_valid = 1'b0;
        sample(); sample();
        check("midrst_new_valid", sum_valid, 1);
        check("midrst_new_sum", sum_data, 3);
        repeat (3) sample();
        check("midrst_new_count", n_sum - base_s, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
